if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Instruction fetch stage sitting directly upstream of the decode stage. Owns the architectural PC and issues word fetches to instruction memory over a req/ack handshake. Registers the instruction, its PC and PC+4 for decode. Accepts registered branch/jump redirects (one delay slot) and the decode freeze request, and inserts NOPs (32'h0) on bubbles.

Parameters:
RESET_PC, 32'h0040_0000, first fetch address after reset
MAX_WAIT, 15, cycles an outstanding request may wait before Fetch_Error_OUT sets
WAIT_W, 4, width of the wait counter; must satisfy 2**WAIT_W > MAX_WAIT

Ports:
CLK  input  1  clock, all logic on posedge
RESET  input  1  synchronous, active-high reset
Alt_PC_IN  input  32  redirect target from decode (registered there)
Request_Alt_PC_IN  input  1  redirect valid this cycle
FREEZE_IN  input  1  decode WANT_FREEZE; hold outputs and PC
IMem_Req_OUT  output  1  fetch request valid
IMem_Addr_OUT  output  32  word-aligned fetch address
IMem_Ack_IN  input  1  data valid for the current request; may arrive in the issue cycle
IMem_Data_IN  input  32  instruction word
Instr1_OUT  output  32  instruction to decode (0 = NOP)
Instr_PC_OUT  output  32  PC of Instr1_OUT
Instr_PC_Plus4_OUT  output  32  Instr_PC_OUT + 4, modulo 2^32
Fetch_Error_OUT  output  1  sticky: timeout or misaligned redirect

Behaviour:
- Reset (synchronous, high): pc_reg=RESET_PC; Instr1_OUT, Instr_PC_OUT, Instr_PC_Plus4_OUT = 0; IMem_Req_OUT=0; Fetch_Error_OUT=0; pending_redirect=0; squash=0; hold buffer empty; wait counter=0; state=ISSUE from the next cycle. Reset mid-transaction abandons the request; a late ack arriving after reset is ignored because state is ISSUE with no request outstanding.
- States: ISSUE, WAIT, HOLD.
- ISSUE: IMem_Req_OUT=1 unless FREEZE_IN=1. The fetch address is combinational with priority Request_Alt_PC_IN ? Alt_PC_IN : pending_redirect ? pending_pc : pc_reg. It is latched into req_addr.
  - Ack in the same cycle: the word is delivered at the next edge.
  - No ack: go to WAIT.
- WAIT: IMem_Req_OUT=1 with IMem_Addr_OUT=req_addr, held stable.
  - Ack: deliver the word, or discard it if squash=1.
  - Wait counter increments each cycle. When it reaches MAX_WAIT, Fetch_Error_OUT is set and the stage keeps waiting.
- Deliver (ack, not squashed, FREEZE_IN=0): Instr1_OUT<=IMem_Data_IN; Instr_PC_OUT<=req_addr; Instr_PC_Plus4_OUT<=req_addr+4; pc_reg<=req_addr+4; clear pending_redirect; go to ISSUE. Throughput with a zero-wait memory is 1 instruction per cycle.
- Bubble (any cycle with no delivery and FREEZE_IN=0): Instr1_OUT<=0; PC outputs hold.
- Redirect:
  - Seen while in ISSUE: takes effect on that issue.
  - Seen while in WAIT: sets squash=1, pending_pc=Alt_PC_IN, pending_redirect=1. The returning word is dropped (bubble), then the stage reissues at pending_pc.
  - The delay-slot instruction already on Instr1_OUT is never squashed.
- Misaligned Alt_PC_IN (bits [1:0] != 0): Fetch_Error_OUT<=1; target used with bits [1:0] cleared.
- Freeze (FREEZE_IN=1):
  - All Instr*_OUT registers hold, so decode re-sees the same instruction. No new request is issued.
  - An outstanding request still completes; its word goes to the 1-entry hold buffer (state HOLD). On unfreeze it is delivered next edge without refetch.
  - A redirect during freeze sets pending_redirect and marks any buffered or in-flight word squashed.
- Simultaneous redirect + unfreeze: redirect wins; any buffered word is discarded.
- Fetch_Error_OUT is cleared only by RESET.

Optional Feature:
IF_PERF_COUNTERS_EN:
- Defined: adds outputs Perf_Fetched_OUT[31:0] (delivered instructions), Perf_Stall_OUT[31:0] (cycles in WAIT or FREEZE_IN=1) and Perf_Squash_OUT[15:0] (discarded words). All are reset to 0, saturating at all-ones.
- Undefined: these ports and their registers do not exist; all other behaviour is identical.

Decomposition:
- Package if_pkg: state enum (ISSUE, WAIT, HOLD), NOP_INSTR=32'h0, default RESET_PC constant, INSTR_BYTES=4.
- One sub-module, if_pc_gen: owns pc_reg, pending_redirect/pending_pc, the next-address priority mux, the alignment check and the +4 adder.
- The handshake FSM, hold buffer and squash logic stay in the top module.

Test Plan:
- Reset release, zero-wait memory returning addr as data -> Instr_PC_OUT sequence 0x00400000, 0x00400004, 0x00400008 on consecutive cycles; Instr_PC_Plus4_OUT = PC+4; Fetch_Error_OUT=0.
- Request_Alt_PC_IN=1, Alt_PC_IN=0x00400100 while the delay slot 0x00400008 sits on Instr1_OUT -> next delivered PC 0x00400100; 0x00400008 not dropped.
- 3-cycle memory latency with a redirect to 0x00400200 during WAIT -> one NOP bubble after the ack, then a request at 0x00400200; the returned stale word never appears on Instr1_OUT.
- FREEZE_IN=1 for 4 cycles with Instr1_OUT=0x0000000C -> outputs stable for 4 cycles, IMem_Req_OUT=0; the in-flight word is buffered and delivered the cycle after unfreeze.
- Ack withheld for 16 cycles -> Fetch_Error_OUT=1 after 15 waiting cycles; it stays 1 after a late ack, until RESET.
- Alt_PC_IN=0x00400102 -> fetch at 0x00400100; Fetch_Error_OUT=1.

Source files
------------

// File: rtl/if_pkg.sv
// Shared types and constants for the instruction fetch stage.
package if_pkg;

    typedef enum logic [1:0] {
        ISSUE = 2'd0,
        WAIT  = 2'd1,
        HOLD  = 2'd2
    } if_state_t;

    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0040_0000;
    localparam logic [31:0] INSTR_BYTES      = 32'd4;

endpackage

// File: rtl/if_pc_gen.sv
// PC generator: architectural PC, pending redirect target, next fetch
// address priority mux, redirect alignment check and the +4 adder.
module if_pc_gen
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Alt_PC_IN,
    input  logic        Request_Alt_PC_IN,
    input  logic        deliver,
    input  logic [31:0] dlv_addr,
    output logic [31:0] fetch_addr,
    output logic [31:0] dlv_addr_plus4,
    output logic        misaligned
);

    logic [31:0] pc_reg;
    logic [31:0] pending_pc;
    logic        pending_redirect;
    logic [31:0] alt_aligned;

    assign alt_aligned    = {Alt_PC_IN[31:2], 2'b00};
    assign misaligned     = Request_Alt_PC_IN && (Alt_PC_IN[1:0] != 2'b00);
    assign dlv_addr_plus4 = dlv_addr + INSTR_BYTES;

    // A live redirect beats a remembered one, which beats sequential flow.
    always_comb begin
        fetch_addr = pc_reg;
        if (Request_Alt_PC_IN)
            fetch_addr = alt_aligned;
        else if (pending_redirect)
            fetch_addr = pending_pc;
    end

    // Advance the PC on delivery; otherwise remember any redirect for the next issue.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc_reg           <= RESET_PC;
            pending_pc       <= 32'h0;
            pending_redirect <= 1'b0;
        end else if (deliver) begin
            pc_reg           <= dlv_addr_plus4;
            pending_redirect <= 1'b0;
        end else if (Request_Alt_PC_IN) begin
            pending_pc       <= alt_aligned;
            pending_redirect <= 1'b1;
        end
    end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: req/ack handshake to instruction memory,
// one-entry hold buffer for words returning during a freeze, squash of
// words made stale by a redirect, and registered outputs to decode.
// Optional macro IF_PERF_COUNTERS_EN adds fetched/stall/squash counters.
//
// state | meaning
// ISSUE | presenting a new fetch address (request dropped while frozen)
// WAIT  | request outstanding, address held stable until ack
// HOLD  | word returned during freeze, parked until unfreeze
module if_fetch_stage
    import if_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter int          MAX_WAIT = 15,
    parameter int          WAIT_W   = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [31:0] Alt_PC_IN,
    input  logic        Request_Alt_PC_IN,
    input  logic        FREEZE_IN,
    output logic        IMem_Req_OUT,
    output logic [31:0] IMem_Addr_OUT,
    input  logic        IMem_Ack_IN,
    input  logic [31:0] IMem_Data_IN,
    output logic [31:0] Instr1_OUT,
    output logic [31:0] Instr_PC_OUT,
    output logic [31:0] Instr_PC_Plus4_OUT,
    output logic        Fetch_Error_OUT
`ifdef IF_PERF_COUNTERS_EN
    ,
    output logic [31:0] Perf_Fetched_OUT,
    output logic [31:0] Perf_Stall_OUT,
    output logic [15:0] Perf_Squash_OUT
`endif
);

    if_state_t          state, state_n;
    logic [31:0]        req_addr;
    logic [31:0]        hold_data;
    logic               squash_q, squash_n, squash_now;
    logic [WAIT_W-1:0]  wait_tmr;
    logic               imem_req, ack_v, timeout;
    logic               deliver, discard, load_hold;
    logic [31:0]        fetch_addr, dlv_addr, dlv_addr_plus4, dlv_data;
    logic               misaligned;

    if_pc_gen #(.RESET_PC(RESET_PC)) u_pc_gen (
        .CLK               (CLK),
        .RESET             (RESET),
        .Alt_PC_IN         (Alt_PC_IN),
        .Request_Alt_PC_IN (Request_Alt_PC_IN),
        .deliver           (deliver),
        .dlv_addr          (dlv_addr),
        .fetch_addr        (fetch_addr),
        .dlv_addr_plus4    (dlv_addr_plus4),
        .misaligned        (misaligned)
    );

    assign imem_req      = !RESET && (((state == ISSUE) && !FREEZE_IN) || (state == WAIT));
    assign ack_v         = imem_req && IMem_Ack_IN;
    assign IMem_Req_OUT  = imem_req;
    assign IMem_Addr_OUT = (state == ISSUE) ? fetch_addr : req_addr;
    assign dlv_addr      = (state == ISSUE) ? fetch_addr : req_addr;
    assign dlv_data      = (state == HOLD) ? hold_data : IMem_Data_IN;
    assign squash_now    = squash_q || Request_Alt_PC_IN;
    assign timeout       = (state == WAIT) && !ack_v && (wait_tmr == WAIT_W'(1));

    // Next state, delivery/discard decisions and squash tracking.
    always_comb begin
        state_n   = state;
        deliver   = 1'b0;
        discard   = 1'b0;
        load_hold = 1'b0;
        squash_n  = squash_q;
        case (state)
            ISSUE: begin
                squash_n = 1'b0;
                if (ack_v)
                    deliver = 1'b1;
                else if (imem_req)
                    state_n = WAIT;
            end
            WAIT: begin
                if (ack_v) begin
                    squash_n = 1'b0;
                    if (squash_now) begin
                        discard = 1'b1;
                        state_n = ISSUE;
                    end else if (FREEZE_IN) begin
                        load_hold = 1'b1;
                        state_n   = HOLD;
                    end else begin
                        deliver = 1'b1;
                        state_n = ISSUE;
                    end
                end else begin
                    squash_n = squash_now;
                end
            end
            HOLD: begin
                if (FREEZE_IN) begin
                    squash_n = squash_now;
                end else begin
                    squash_n = 1'b0;
                    state_n  = ISSUE;
                    if (squash_now)
                        discard = 1'b1;
                    else
                        deliver = 1'b1;
                end
            end
            default: state_n = ISSUE;
        endcase
    end

    // State, squash flag, latched request address and hold buffer.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state     <= ISSUE;
            squash_q  <= 1'b0;
            req_addr  <= 32'h0;
            hold_data <= 32'h0;
        end else begin
            state    <= state_n;
            squash_q <= squash_n;
            if ((state == ISSUE) && imem_req)
                req_addr <= fetch_addr;
            if (load_hold)
                hold_data <= IMem_Data_IN;
        end
    end

    // Wait timer counts down from MAX_WAIT; reaching 1 in WAIT without ack is the timeout.
    always_ff @(posedge CLK) begin
        if (RESET)
            wait_tmr <= '0;
        else if ((state == ISSUE) && (state_n == WAIT))
            wait_tmr <= WAIT_W'(MAX_WAIT);
        else if ((state == WAIT) && !ack_v && (wait_tmr != '0))
            wait_tmr <= wait_tmr - 1'b1;
    end

    // Sticky error, cleared only by reset.
    always_ff @(posedge CLK) begin
        if (RESET)
            Fetch_Error_OUT <= 1'b0;
        else if (timeout || misaligned)
            Fetch_Error_OUT <= 1'b1;
    end

    // Decode-facing registers: load on delivery, NOP on bubble, hold while frozen.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            Instr1_OUT         <= NOP_INSTR;
            Instr_PC_OUT       <= 32'h0;
            Instr_PC_Plus4_OUT <= 32'h0;
        end else if (deliver) begin
            Instr1_OUT         <= dlv_data;
            Instr_PC_OUT       <= dlv_addr;
            Instr_PC_Plus4_OUT <= dlv_addr_plus4;
        end else if (!FREEZE_IN) begin
            Instr1_OUT         <= NOP_INSTR;
        end
    end

`ifdef IF_PERF_COUNTERS_EN
    // Saturating performance counters.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            Perf_Fetched_OUT <= 32'h0;
            Perf_Stall_OUT   <= 32'h0;
            Perf_Squash_OUT  <= 16'h0;
        end else begin
            if (deliver && !(&Perf_Fetched_OUT))
                Perf_Fetched_OUT <= Perf_Fetched_OUT + 32'd1;
            if (((state == WAIT) || FREEZE_IN) && !(&Perf_Stall_OUT))
                Perf_Stall_OUT <= Perf_Stall_OUT + 32'd1;
            if (discard && !(&Perf_Squash_OUT))
                Perf_Squash_OUT <= Perf_Squash_OUT + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed self-checking bench for if_fetch_stage.
module tb_if_fetch_stage;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [31:0] Alt_PC_IN = 32'h0;
    logic        Request_Alt_PC_IN = 1'b0;
    logic        FREEZE_IN = 1'b0;
    logic        IMem_Req_OUT;
    logic [31:0] IMem_Addr_OUT;
    logic        IMem_Ack_IN = 1'b0;
    logic [31:0] IMem_Data_IN = 32'h0;
    logic [31:0] Instr1_OUT;
    logic [31:0] Instr_PC_OUT;
    logic [31:0] Instr_PC_Plus4_OUT;
    logic        Fetch_Error_OUT;
`ifdef IF_PERF_COUNTERS_EN
    logic [31:0] Perf_Fetched_OUT;
    logic [31:0] Perf_Stall_OUT;
    logic [15:0] Perf_Squash_OUT;
`endif

    int total = 0;
    int bad   = 0;

    if_fetch_stage dut (
        .CLK                (CLK),
        .RESET              (RESET),
        .Alt_PC_IN          (Alt_PC_IN),
        .Request_Alt_PC_IN  (Request_Alt_PC_IN),
        .FREEZE_IN          (FREEZE_IN),
        .IMem_Req_OUT       (IMem_Req_OUT),
        .IMem_Addr_OUT      (IMem_Addr_OUT),
        .IMem_Ack_IN        (IMem_Ack_IN),
        .IMem_Data_IN       (IMem_Data_IN),
        .Instr1_OUT         (Instr1_OUT),
        .Instr_PC_OUT       (Instr_PC_OUT),
        .Instr_PC_Plus4_OUT (Instr_PC_Plus4_OUT),
        .Fetch_Error_OUT    (Fetch_Error_OUT)
`ifdef IF_PERF_COUNTERS_EN
        ,
        .Perf_Fetched_OUT   (Perf_Fetched_OUT),
        .Perf_Stall_OUT     (Perf_Stall_OUT),
        .Perf_Squash_OUT    (Perf_Squash_OUT)
`endif
    );

    always #5 CLK = ~CLK;

    // Drive one cycle's inputs; echo returns the presented address as the instruction word.
    task automatic set_in(input logic ack, input logic rq, input logic [31:0] alt,
                          input logic frz, input logic echo, input logic [31:0] dat);
        IMem_Ack_IN       = ack;
        Request_Alt_PC_IN = rq;
        Alt_PC_IN         = alt;
        FREEZE_IN         = frz;
        #1;
        IMem_Data_IN = echo ? IMem_Addr_OUT : dat;
        #1;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        set_in(0, 0, 32'h0, 0, 0, 32'h0);
        repeat (3) tick();
        total++; if (Instr1_OUT !== 32'h0) begin bad++; $display("FAIL reset_instr act=%h exp=0", Instr1_OUT); end
        total++; if (Instr_PC_OUT !== 32'h0) begin bad++; $display("FAIL reset_pc act=%h exp=0", Instr_PC_OUT); end
        total++; if (Instr_PC_Plus4_OUT !== 32'h0) begin bad++; $display("FAIL reset_pc4 act=%h exp=0", Instr_PC_Plus4_OUT); end
        total++; if (Fetch_Error_OUT !== 1'b0) begin bad++; $display("FAIL reset_err act=%b exp=0", Fetch_Error_OUT); end
        total++; if (IMem_Req_OUT !== 1'b0) begin bad++; $display("FAIL reset_req act=%b exp=0", IMem_Req_OUT); end
        RESET = 1'b0;
        #1;
        total++; if (IMem_Req_OUT !== 1'b1) begin bad++; $display("FAIL first_req act=%b exp=1", IMem_Req_OUT); end
        total++; if (IMem_Addr_OUT !== 32'h0040_0000) begin bad++; $display("FAIL first_addr act=%h exp=00400000", IMem_Addr_OUT); end
    endtask

    task automatic test_sequential();
        logic [31:0] exp;
        for (int k = 0; k < 3; k++) begin
            set_in(1, 0, 32'h0, 0, 1, 32'h0);
            tick();
            exp = 32'h0040_0000 + 32'(4 * k);
            total++; if (Instr_PC_OUT !== exp) begin bad++; $display("FAIL seq_pc%0d act=%h exp=%h", k, Instr_PC_OUT, exp); end
            total++; if (Instr1_OUT !== exp) begin bad++; $display("FAIL seq_instr%0d act=%h exp=%h", k, Instr1_OUT, exp); end
            total++; if (Instr_PC_Plus4_OUT !== exp + 32'd4) begin bad++; $display("FAIL seq_pc4_%0d act=%h exp=%h", k, Instr_PC_Plus4_OUT, exp + 32'd4); end
        end
        total++; if (Fetch_Error_OUT !== 1'b0) begin bad++; $display("FAIL seq_err act=%b exp=0", Fetch_Error_OUT); end
    endtask

    task automatic test_redirect_delay_slot();
        total++; if (Instr1_OUT !== 32'h0040_0008) begin bad++; $display("FAIL slot_kept act=%h exp=00400008", Instr1_OUT); end
        set_in(1, 1, 32'h0040_0100, 0, 1, 32'h0);
        total++; if (IMem_Addr_OUT !== 32'h0040_0100) begin bad++; $display("FAIL redir_addr act=%h exp=00400100", IMem_Addr_OUT); end
        tick();
        total++; if (Instr_PC_OUT !== 32'h0040_0100) begin bad++; $display("FAIL redir_pc act=%h exp=00400100", Instr_PC_OUT); end
        set_in(1, 0, 32'h0, 0, 1, 32'h0);
        tick();
        total++; if (Instr_PC_OUT !== 32'h0040_0104) begin bad++; $display("FAIL redir_next act=%h exp=00400104", Instr_PC_OUT); end
    endtask

    task automatic test_wait_redirect();
        set_in(0, 0, 32'h0, 0, 0, 32'h0);
        tick();
        total++; if (Instr1_OUT !== 32'h0) begin bad++; $display("FAIL wait_bubble act=%h exp=0", Instr1_OUT); end
        total++; if (Instr_PC_OUT !== 32'h0040_0104) begin bad++; $display("FAIL wait_pc_hold act=%h exp=00400104", Instr_PC_OUT); end
        set_in(0, 1, 32'h0040_0200, 0, 0, 32'h0);
        total++; if (IMem_Addr_OUT !== 32'h0040_0108) begin bad++; $display("FAIL wait_addr_stable act=%h exp=00400108", IMem_Addr_OUT); end
        tick();
        set_in(1, 0, 32'h0, 0, 0, 32'hDEAD_BEEF);
        tick();
        total++; if (Instr1_OUT !== 32'h0) begin bad++; $display("FAIL stale_dropped act=%h exp=0", Instr1_OUT); end
        set_in(1, 0, 32'h0, 0, 1, 32'h0);
        total++; if (IMem_Addr_OUT !== 32'h0040_0200) begin bad++; $display("FAIL reissue_addr act=%h exp=00400200", IMem_Addr_OUT); end
        tick();
        total++; if (Instr1_OUT !== 32'h0040_0200) begin bad++; $display("FAIL reissue_instr act=%h exp=00400200", Instr1_OUT); end
        total++; if (Instr_PC_Plus4_OUT !== 32'h0040_0204) begin bad++; $display("FAIL reissue_pc4 act=%h exp=00400204", Instr_PC_Plus4_OUT); end
    endtask

    task automatic test_freeze();
        set_in(1, 0, 32'h0, 0, 0, 32'h0000_000C);
        tick();
        for (int i = 0; i < 4; i++) begin
            set_in(0, 0, 32'h0, 1, 0, 32'h0);
            total++; if (IMem_Req_OUT !== 1'b0) begin bad++; $display("FAIL frz_req%0d act=%b exp=0", i, IMem_Req_OUT); end
            tick();
            total++; if (Instr1_OUT !== 32'h0000_000C) begin bad++; $display("FAIL frz_instr%0d act=%h exp=0000000c", i, Instr1_OUT); end
            total++; if (Instr_PC_OUT !== 32'h0040_0204) begin bad++; $display("FAIL frz_pc%0d act=%h exp=00400204", i, Instr_PC_OUT); end
        end
        set_in(1, 0, 32'h0, 0, 1, 32'h0);
        tick();
        total++; if (Instr_PC_OUT !== 32'h0040_0208) begin bad++; $display("FAIL unfrz_pc act=%h exp=00400208", Instr_PC_OUT); end
        // in-flight word returns during freeze and is buffered
        set_in(0, 0, 32'h0, 0, 0, 32'h0);
        tick();
        set_in(1, 0, 32'h0, 1, 0, 32'hA5A5_0001);
        total++; if (IMem_Req_OUT !== 1'b1) begin bad++; $display("FAIL frz_outstanding_req act=%b exp=1", IMem_Req_OUT); end
        tick();
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 32'h0, 1, 0, 32'h0);
            total++; if (IMem_Req_OUT !== 1'b0) begin bad++; $display("FAIL hold_req%0d act=%b exp=0", i, IMem_Req_OUT); end
            tick();
            total++; if (Instr1_OUT !== 32'h0) begin bad++; $display("FAIL hold_instr%0d act=%h exp=0", i, Instr1_OUT); end
        end
        set_in(0, 0, 32'h0, 0, 0, 32'h0);
        tick();
        total++; if (Instr1_OUT !== 32'hA5A5_0001) begin bad++; $display("FAIL buf_instr act=%h exp=a5a50001", Instr1_OUT); end
        total++; if (Instr_PC_OUT !== 32'h0040_020C) begin bad++; $display("FAIL buf_pc act=%h exp=0040020c", Instr_PC_OUT); end
        total++; if (Instr_PC_Plus4_OUT !== 32'h0040_0210) begin bad++; $display("FAIL buf_pc4 act=%h exp=00400210", Instr_PC_Plus4_OUT); end
        #1;
        total++; if (IMem_Addr_OUT !== 32'h0040_0210) begin bad++; $display("FAIL buf_next_addr act=%h exp=00400210", IMem_Addr_OUT); end
    endtask

    task automatic test_hold_redirect();
        set_in(0, 0, 32'h0, 0, 0, 32'h0);
        tick();
        set_in(1, 0, 32'h0, 1, 0, 32'h1111_2222);
        tick();
        set_in(0, 1, 32'h0040_0300, 0, 0, 32'h0);
        tick();
        total++; if (Instr1_OUT !== 32'h0) begin bad++; $display("FAIL hold_discard act=%h exp=0", Instr1_OUT); end
        total++; if (Instr_PC_OUT !== 32'h0040_020C) begin bad++; $display("FAIL hold_discard_pc act=%h exp=0040020c", Instr_PC_OUT); end
        set_in(1, 0, 32'h0, 0, 1, 32'h0);
        total++; if (IMem_Addr_OUT !== 32'h0040_0300) begin bad++; $display("FAIL hold_redir_addr act=%h exp=00400300", IMem_Addr_OUT); end
        tick();
        total++; if (Instr1_OUT !== 32'h0040_0300) begin bad++; $display("FAIL hold_redir_instr act=%h exp=00400300", Instr1_OUT); end
    endtask

    task automatic test_timeout();
        set_in(0, 0, 32'h0, 0, 0, 32'h0);
        tick();
        for (int i = 1; i <= 15; i++) begin
            set_in(0, 0, 32'h0, 0, 0, 32'h0);
            tick();
            if (i == 14) begin
                total++; if (Fetch_Error_OUT !== 1'b0) begin bad++; $display("FAIL tmo_early act=%b exp=0", Fetch_Error_OUT); end
            end
            if (i == 15) begin
                total++; if (Fetch_Error_OUT !== 1'b1) begin bad++; $display("FAIL tmo_set act=%b exp=1", Fetch_Error_OUT); end
            end
        end
        set_in(1, 0, 32'h0, 0, 1, 32'h0);
        tick();
        total++; if (Instr_PC_OUT !== 32'h0040_0304) begin bad++; $display("FAIL late_ack_pc act=%h exp=00400304", Instr_PC_OUT); end
        repeat (2) begin
            set_in(1, 0, 32'h0, 0, 1, 32'h0);
            tick();
        end
        total++; if (Fetch_Error_OUT !== 1'b1) begin bad++; $display("FAIL tmo_sticky act=%b exp=1", Fetch_Error_OUT); end
        RESET = 1'b1;
        set_in(0, 0, 32'h0, 0, 0, 32'h0);
        tick();
        total++; if (Fetch_Error_OUT !== 1'b0) begin bad++; $display("FAIL tmo_reset_clear act=%b exp=0", Fetch_Error_OUT); end
        RESET = 1'b0;
    endtask

    task automatic test_misaligned();
        set_in(1, 1, 32'h0040_0102, 0, 1, 32'h0);
        total++; if (IMem_Addr_OUT !== 32'h0040_0100) begin bad++; $display("FAIL mis_addr act=%h exp=00400100", IMem_Addr_OUT); end
        tick();
        total++; if (Instr_PC_OUT !== 32'h0040_0100) begin bad++; $display("FAIL mis_pc act=%h exp=00400100", Instr_PC_OUT); end
        total++; if (Fetch_Error_OUT !== 1'b1) begin bad++; $display("FAIL mis_err act=%b exp=1", Fetch_Error_OUT); end
        set_in(1, 0, 32'h0, 0, 1, 32'h0);
        tick();
        total++; if (Instr_PC_OUT !== 32'h0040_0104) begin bad++; $display("FAIL mis_next act=%h exp=00400104", Instr_PC_OUT); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect_delay_slot();
        test_wait_redirect();
        test_freeze();
        test_hold_redirect();
        test_timeout();
        test_misaligned();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
